// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared types and helpers for the configuration-chain loader.
//   ccffState_e : loader FSM states (IDLE, WAIT_WORD, SHIFT, DONE)
//   words_for   : number of bitstream words needed to fill a chain
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } ccffState_e;

    // Words needed to cover chainLen bits; the final word may be partial.
    function automatic int words_for(input int chainLen, input int wordW);
        return (chainLen + wordW - 1) / wordW;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer
// Holds one bitstream word and hands it out LSB-first, tracking how many
// bits of the current word are still to be presented.
// Ports:
//   i_clk    in   clock (rising edge)
//   i_reset  in   synchronous active-high reset
//   i_load   in   capture i_data and i_n
//   i_data   in   WORD_W-bit word
//   i_n      in   number of bits of this word that will be used
//   i_shift  in   consume the current bit
//   o_bit    out  current bit (LSB of the shift register)
//   o_last   out  current bit is the last one of this word
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int NW     = $clog2(WORD_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [NW-1:0]     i_n,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_last
);

    logic [WORD_W-1:0] r_sr;
    logic [NW-1:0]     r_bitsLeft;

    // Load a fresh word or shift the current one right by one bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sr       <= '0;
            r_bitsLeft <= '0;
        end else if (i_load) begin
            r_sr       <= i_data;
            r_bitsLeft <= i_n;
        end else if (i_shift) begin
            r_sr       <= r_sr >> 1;
            r_bitsLeft <= r_bitsLeft - NW'(1);
        end
    end

    assign o_bit  = r_sr[0];
    assign o_last = (r_bitsLeft == NW'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Streams bitstream words from a valid/ready port onto a serial configuration
// chain (ccff_head -> ccff_tail), advancing the chain exactly CHAIN_LEN times
// per load and then pulsing done.
// Build option: define CCFF_READBACK_EN to add rb_data/rb_valid, which pack
// the bits leaving ccff_tail into words.
// Ports:
//   prog_clk     in   configuration clock
//   prog_reset   in   synchronous active-high reset
//   start        in   begin a load (IDLE only)
//   abort        in   cancel the load in progress
//   cfg_data     in   bitstream word, LSB first
//   cfg_valid    in   cfg_data valid
//   cfg_ready    out  word accepted on cfg_valid && cfg_ready
//   ccff_head    out  registered serial bit into the chain
//   ccff_clk_en  out  registered chain shift enable
//   ccff_tail    in   serial output of the chain
//   busy         out  loader not IDLE
//   done         out  one-cycle pulse after the last chain shift
//   rb_data      out  (CCFF_READBACK_EN) readback word
//   rb_valid     out  (CCFF_READBACK_EN) rb_data valid
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 400,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NW    = $clog2(WORD_W + 1);

    ccffState_e       r_state;
    ccffState_e       w_nextState;
    logic [CNT_W-1:0] r_remaining;
    logic             r_head;
    logic             r_clkEn;
    logic             r_done;
    logic             w_load;
    logic             w_shift;
    logic             w_serBit;
    logic             w_serLast;
    logic [NW-1:0]    w_wordBits;

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        w_nextState = r_state;
        if (r_state != IDLE && abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (start) w_nextState = WAIT_WORD;
                WAIT_WORD: if (cfg_valid) w_nextState = SHIFT;
                SHIFT: begin
                    if (w_serLast) begin
                        w_nextState = (r_remaining == CNT_W'(1)) ? DONE : WAIT_WORD;
                    end
                end
                DONE:      w_nextState = IDLE;
                default:   w_nextState = IDLE;
            endcase
        end
    end

    // State-decoded controls. Gating cfg_ready with abort means an aborted
    // cycle never completes a handshake.
    always_comb begin
        cfg_ready = (r_state == WAIT_WORD) && !abort;
        busy      = (r_state != IDLE);
        w_load    = cfg_ready && cfg_valid;
        w_shift   = (r_state == SHIFT) && !abort;
    end

    // The final word may hold fewer useful bits than WORD_W.
    assign w_wordBits = (32'(r_remaining) >= WORD_W) ? NW'(WORD_W) : NW'(r_remaining);

    // Registered chain drive, remaining-bit counter and done pulse. The
    // enable only rises for a cycle that actually presents a bit, so stalls
    // and gaps leave the chain untouched.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_remaining <= '0;
            r_head      <= 1'b0;
            r_clkEn     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_clkEn <= w_shift;
            r_head  <= w_shift ? w_serBit : 1'b0;
            r_done  <= (r_state == DONE) && !abort;
            if (r_state == IDLE && start) begin
                r_remaining <= CNT_W'(CHAIN_LEN);
            end else if (w_shift) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign ccff_head   = r_head;
    assign ccff_clk_en = r_clkEn;
    assign done        = r_done;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .i_clk   (prog_clk),
        .i_reset (prog_reset),
        .i_load  (w_load),
        .i_data  (cfg_data),
        .i_n     (w_wordBits),
        .i_shift (w_shift),
        .o_bit   (w_serBit),
        .o_last  (w_serLast)
    );

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] r_rbAcc;
    logic [NW-1:0]     r_rbCnt;
    logic              r_headLast;
    logic [WORD_W-1:0] w_rbWord;
    logic              w_rbFire;

    // The tail bit leaving the chain is merged into the word being built in
    // the same cycle, so the last partial word is reported while the final
    // shift is presented, ahead of done.
    assign w_rbWord = r_rbAcc | (WORD_W'(ccff_tail) << r_rbCnt);
    assign w_rbFire = r_clkEn && ((r_rbCnt == NW'(WORD_W - 1)) || r_headLast);
    assign rb_valid = w_rbFire;
    assign rb_data  = w_rbFire ? w_rbWord : '0;

    // Readback accumulator, cleared whenever the loader is idle.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_rbAcc    <= '0;
            r_rbCnt    <= '0;
            r_headLast <= 1'b0;
        end else begin
            r_headLast <= w_shift && (r_remaining == CNT_W'(1));
            if (r_state == IDLE) begin
                r_rbAcc <= '0;
                r_rbCnt <= '0;
            end else if (r_clkEn) begin
                if (w_rbFire) begin
                    r_rbAcc <= '0;
                    r_rbCnt <= '0;
                end else begin
                    r_rbAcc <= w_rbWord;
                    r_rbCnt <= r_rbCnt + NW'(1);
                end
            end
        end
    end
`else
    logic w_unusedTail;
    assign w_unusedTail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
// Directed bench for ccff_chain_loader with CHAIN_LEN=10, WORD_W=4 and a
// behavioural 10-DFF chain hung off ccff_head/ccff_clk_en/ccff_tail.
// Readback checks are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

    localparam int CL = 10;
    localparam int WW = 4;

    logic          prog_clk;
    logic          prog_reset;
    logic          start;
    logic          abort;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_clk_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
`ifdef CCFF_READBACK_EN
    logic [WW-1:0] rb_data;
    logic          rb_valid;
`endif

    logic [CL-1:0] chain;
    logic [CL-1:0] preloadVal;
    logic          preloadReq;

    int            checks;
    int            passes;
    int            cycleCnt;
    int            enCnt;
    int            doneCnt;
    int            firstEnCycle;
    int            hsCycle;
    int            doneCycle;
    int            rbN;
    int            lastRbCycle;
    logic [31:0]   headBits;
    logic [WW-1:0] rbWords [0:7];

    ccff_chain_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .start       (start),
        .abort       (abort),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data     (rb_data),
        .rb_valid    (rb_valid)
`endif
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Behavioural chain: newest bit enters at the top, the first-shifted
    // bit ends up at chain[0], which is the tail.
    always @(posedge prog_clk) begin
        if (preloadReq) begin
            chain <= preloadVal;
        end else if (ccff_clk_en) begin
            chain <= {ccff_head, chain[CL-1:1]};
        end
    end
    assign ccff_tail = chain[0];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and log what the DUT presents in the new cycle.
    task automatic tick();
        @(posedge prog_clk);
        @(negedge prog_clk);
        cycleCnt++;
        if (ccff_clk_en) begin
            if (firstEnCycle < 0) firstEnCycle = cycleCnt;
            if (enCnt < 32) headBits[enCnt] = ccff_head;
            enCnt++;
        end
        if (done) begin
            doneCnt++;
            doneCycle = cycleCnt;
        end
`ifdef CCFF_READBACK_EN
        if (rb_valid) begin
            if (rbN < 8) rbWords[rbN] = rb_data;
            rbN++;
            lastRbCycle = cycleCnt;
        end
`endif
    endtask

    task automatic clearLog();
        enCnt        = 0;
        doneCnt      = 0;
        headBits     = '0;
        firstEnCycle = -1;
        hsCycle      = -1;
        doneCycle    = -1;
        rbN          = 0;
        lastRbCycle  = -1;
    endtask

    task automatic sendWord(input logic [WW-1:0] d);
        cfg_data  = d;
        cfg_valid = 1'b1;
        for (int i = 0; i < 40 && !cfg_ready; i++) tick();
        checkOutput("handshake_ready", 32'(cfg_ready), 32'd1);
        if (cfg_ready) begin
            if (hsCycle < 0) hsCycle = cycleCnt + 1;
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 60 && doneCnt == 0; i++) tick();
        tick();
    endtask

    // Full load of words 0xA, 0x5, 0x3 with an optional gap between words.
    task automatic applyStimulus(input int gap);
        logic [11:0] stream;
        stream = 12'h35A;
        clearLog();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w > 0 && gap > 0) begin
                repeat (gap) tick();
                checkOutput($sformatf("gap_clk_en_w%0d", w), 32'(ccff_clk_en), 32'd0);
                checkOutput($sformatf("gap_ready_w%0d", w), 32'(cfg_ready), 32'd1);
            end
            sendWord(stream[w*4 +: 4]);
        end
        waitDone();
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        cycleCnt   = 0;
        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_data   = '0;
        cfg_valid  = 1'b0;
        preloadReq = 1'b1;
        preloadVal = '0;
        clearLog();

        // Reset state.
        tick();
        tick();
        preloadReq = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_clk_en", 32'(ccff_clk_en), 32'd0);
        checkOutput("reset_head", 32'(ccff_head), 32'd0);
        checkOutput("reset_ready", 32'(cfg_ready), 32'd0);
        prog_reset = 1'b0;
        tick();

        // Load with cfg_valid held high.
        applyStimulus(0);
        checkOutput("load1_latency", 32'(firstEnCycle), 32'(hsCycle + 1));
        checkOutput("load1_clk_en_count", 32'(enCnt), 32'd10);
        checkOutput("load1_head_bits", headBits, 32'h35A);
        checkOutput("load1_done_count", 32'(doneCnt), 32'd1);
        checkOutput("load1_chain", 32'(chain), 32'h35A);
        checkOutput("load1_busy_after", 32'(busy), 32'd0);

        // Same load with 5-cycle valid gaps.
        applyStimulus(5);
        checkOutput("load2_clk_en_count", 32'(enCnt), 32'd10);
        checkOutput("load2_head_bits", headBits, 32'h35A);
        checkOutput("load2_done_count", 32'(doneCnt), 32'd1);

        // Abort after six shifted bits.
        clearLog();
        start = 1'b1;
        tick();
        start = 1'b0;
        sendWord(4'hA);
        sendWord(4'h5);
        for (int i = 0; i < 20 && enCnt < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_clk_en", 32'(ccff_clk_en), 32'd0);
        repeat (4) tick();
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        checkOutput("abort_clk_en_count", 32'(enCnt), 32'd6);
        checkOutput("abort_chain_partial", 32'(chain), 32'h1AD);

        // Clean reload after abort.
        applyStimulus(0);
        checkOutput("reload_clk_en_count", 32'(enCnt), 32'd10);
        checkOutput("reload_head_bits", headBits, 32'h35A);
        checkOutput("reload_done_count", 32'(doneCnt), 32'd1);
        checkOutput("reload_chain", 32'(chain), 32'h35A);

        // start during SHIFT is ignored; reset mid-SHIFT returns to IDLE.
        clearLog();
        start = 1'b1;
        tick();
        start = 1'b0;
        sendWord(4'hA);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_in_shift_ready", 32'(cfg_ready), 32'd0);
        checkOutput("start_in_shift_busy", 32'(busy), 32'd1);
        checkOutput("start_in_shift_clk_en", 32'(ccff_clk_en), 32'd1);
        prog_reset = 1'b1;
        tick();
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_clk_en", 32'(ccff_clk_en), 32'd0);
        checkOutput("midreset_head", 32'(ccff_head), 32'd0);
        checkOutput("midreset_ready", 32'(cfg_ready), 32'd0);
        prog_reset = 1'b0;
        tick();
        checkOutput("postreset_busy", 32'(busy), 32'd0);

`ifdef CCFF_READBACK_EN
        // Readback of a preloaded chain.
        preloadVal = 10'b11_0000_1111;
        preloadReq = 1'b1;
        tick();
        preloadReq = 1'b0;
        applyStimulus(0);
        checkOutput("rb_count", 32'(rbN), 32'd3);
        checkOutput("rb_word0", 32'(rbWords[0]), 32'hF);
        checkOutput("rb_word1", 32'(rbWords[1]), 32'h0);
        checkOutput("rb_word2", 32'(rbWords[2]), 32'h3);
        checkOutput("rb_before_done", 32'(lastRbCycle), 32'(doneCycle - 1));
        checkOutput("rb_done_count", 32'(doneCnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
